rf_write_scheduler: RTL and testbench
=====================================

Name: rf_write_scheduler

Overview:
Shares the single register-file write port between the in-order pipeline writeback and the multi-cycle mult/div unit. It owns three pieces of state:
- a small FIFO of completed mult/div results;
- a starvation counter that forces one pipeline hold cycle;
- a 32-bit scoreboard of registers with outstanding mult/div writes, which decode uses for RAW/WAW stalls.

It sits between the WB stage, the mult/div unit and the register file's write port.

Parameters:
BUF_DEPTH, 2, mult/div result FIFO entries (power of two, >=2)
STARVE_LIMIT, 4, cycles a non-empty FIFO may go unserved before hold_pipe asserts (>=1)

Ports:
clock  in  1  clock, rising edge
reset  in  1  synchronous, active-high
pipe_wr_en  in  1  WB stage write request (cannot be back-pressured except via hold_pipe)
pipe_wr_reg  in  5  WB destination register
pipe_wr_data  in  32  WB write data
md_valid  in  1  mult/div result valid
md_ready  out  1  FIFO can accept (not full)
md_reg  in  5  mult/div destination register
md_data  in  32  mult/div result
md_issue  in  1  decode issued a mult/div op this cycle
md_issue_reg  in  5  its destination register
rs  in  5  decode source register 1
rt  in  5  decode source register 2
dec_stall  out  1  busy[rs] | busy[rt] (combinational)
busy_mask  out  32  scoreboard, bit n = register n has a pending mult/div write
hold_pipe  out  1  pipeline must freeze WB this cycle
rf_write_enable  out  1  to register file
rf_write_reg  out  5  to register file
rf_wr_data  out  32  to register file

Behaviour:
- Reset (synchronous, sampled on clock): FIFO emptied, busy_mask=0, wait_cnt=0. Pending results are discarded; no write happens in the reset cycle.
  - Values after the reset edge: md_ready=1, hold_pipe=0, dec_stall=0.
  - While reset=1: rf_write_enable=0, rf_write_reg=0, rf_wr_data=0.
- Write-port mux (combinational, same cycle):
  - pipe_go = pipe_wr_en & (pipe_wr_reg!=0) & ~hold_pipe.
  - pop = FIFO non-empty & ~pipe_go.
  - If pipe_go: port carries the pipe request.
  - Else if pop: port carries the FIFO head.
  - Else: rf_write_enable=0.
- r0:
  - Pipe writes to r0 never use the port.
  - md results with md_reg=0 are handshaken (md_valid & md_ready) and dropped, not enqueued.
- FIFO:
  - md_ready = count<BUF_DEPTH.
  - Push on md_valid & md_ready & md_reg!=0.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Full: md_ready=0 and md_valid is ignored; the mult/div unit must hold its result.
- Starvation:
  - wait_cnt increments each cycle the FIFO is non-empty and not popped, saturating at STARVE_LIMIT.
  - wait_cnt clears on any pop or when the FIFO is empty.
  - hold_pipe = (wait_cnt==STARVE_LIMIT), driven from the register.
  - While hold_pipe=1 the pipeline keeps its WB inputs for the next cycle and the FIFO head is written.
- Scoreboard:
  - md_issue & md_issue_reg!=0 sets busy[md_issue_reg] at the edge.
  - A pop clears busy[head reg]. A set and clear of the same register in the same cycle leaves it set.
  - Decode must not issue a mult/div to a register already busy, and must not issue a pipe write to a busy register. dec_stall plus busy_mask provide this; the block does not check it.
- Latency:
  - Pipe write reaches the port in 0 cycles.
  - A FIFO entry is written 1 cycle after push at best, and at most STARVE_LIMIT+1 cycles after it reaches the head.

Decomposition:
- Shared package (mips_pkg): REG_W=5, DATA_W=32, NUM_REGS=32, REG_ZERO=0.
- One sub-module: rf_result_fifo (parameterised BUF_DEPTH x {reg,data}, push/pop/full/empty/count).
- Arbitration, starvation counter and scoreboard stay in the top.

Test Plan:
- Reset, then md_valid with md_reg=5, md_data=0x1234, pipe idle → next cycle rf_write_enable=1, reg 5, data 0x1234; busy[5] clears.
- pipe_wr_en=1 to reg 7 every cycle; md pushes reg 9 → port serves reg 7 for 4 cycles, hold_pipe=1 on the 5th cycle (port writes reg 9), then pipe resumes.
- Push reg 3 and reg 4 with the pipe busy → md_ready=0 on the 3rd attempt; a third result is held until a pop, then accepted.
- md_issue reg 8, then rs=8 → dec_stall=1 until the reg-8 write pops. Issue and pop of reg 8 in the same cycle → busy[8] stays 1.
- md result to r0 and pipe write to r0 → rf_write_enable stays 0, FIFO count stays 0.
- Reset asserted with 2 FIFO entries and busy_mask=0x30 → after the edge, FIFO empty, busy_mask=0, no write issued.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared register-file types and widths for the MIPS core.
package mips_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;

  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam reg_idx_t REG_ZERO = '0;

  // One pending mult/div writeback.
  typedef struct packed {
    reg_idx_t rd;
    data_t    data;
  } rf_entry_t;

endpackage

// File: rtl/rf_write_scheduler_if.sv
// Mult/div result handshake into the register-file write scheduler.
interface rf_write_scheduler_if;
  import mips_pkg::*;

  logic     md_valid;
  logic     md_ready;
  reg_idx_t md_reg;
  data_t    md_data;

  modport master (output md_valid, output md_reg, output md_data, input md_ready);
  modport slave  (input md_valid, input md_reg, input md_data, output md_ready);

endinterface

// File: rtl/rf_result_fifo.sv
// Small power-of-two FIFO of completed mult/div results awaiting the write port.
module rf_result_fifo
  import mips_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  rf_entry_t                push_entry,
  input  logic                     pop,
  output rf_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(BUF_DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam logic [PtrW:0] Depth = (PtrW + 1)'(BUF_DEPTH);

  rf_entry_t       mem_q [BUF_DEPTH];
  logic [PtrW-1:0] rd_q, wr_q;
  logic [PtrW:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full    = (count_q == Depth);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= push_entry;
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Arbitrates the single register-file write port between WB and buffered mult/div results,
// with a starvation hold and a scoreboard of registers awaiting mult/div writes.
module rf_write_scheduler
  import mips_pkg::*;
#(
  parameter int unsigned BUF_DEPTH    = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pipe_wr_en,
  input  reg_idx_t              pipe_wr_reg,
  input  data_t                 pipe_wr_data,
  rf_write_scheduler_if.slave   md,
  input  logic                  md_issue,
  input  reg_idx_t              md_issue_reg,
  input  reg_idx_t              rs,
  input  reg_idx_t              rt,
  output logic                  dec_stall,
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic                  hold_pipe,
  output logic                  rf_write_enable,
  output reg_idx_t              rf_write_reg,
  output data_t                 rf_wr_data
);

  localparam int unsigned CntW  = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned WaitW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0]  Depth   = CntW'(BUF_DEPTH);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(STARVE_LIMIT);

  logic                pipe_go, pop, push;
  logic                fifo_full, fifo_empty;
  logic [CntW-1:0]     fifo_count;
  rf_entry_t           head, push_entry;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  rf_result_fifo #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  assign md.md_ready = (fifo_count < Depth);
  // r0 results complete the handshake but are never buffered.
  assign push        = md.md_valid & md.md_ready & (md.md_reg != REG_ZERO);
  assign push_entry  = '{rd: md.md_reg, data: md.md_data};

  assign hold_pipe = (wait_q == WaitMax);
  assign pipe_go   = ~reset & pipe_wr_en & (pipe_wr_reg != REG_ZERO) & ~hold_pipe;
  assign pop       = ~reset & ~fifo_empty & ~pipe_go;

  assign busy_mask = busy_q;
  assign dec_stall = busy_q[rs] | busy_q[rt];

  always_comb begin
    rf_write_enable = pipe_go | pop;
    rf_write_reg    = '0;
    rf_wr_data      = '0;
    if (pipe_go) begin
      rf_write_reg = pipe_wr_reg;
      rf_wr_data   = pipe_wr_data;
    end else if (pop) begin
      rf_write_reg = head.rd;
      rf_wr_data   = head.data;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (fifo_empty || pop) begin
      wait_d = '0;
    end else if (wait_q != WaitMax) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // Set after clear so a same-cycle issue to the popped register stays busy.
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[head.rd] = 1'b0;
    if (md_issue && (md_issue_reg != REG_ZERO)) busy_d[md_issue_reg] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_q <= '0;
      busy_q <= '0;
    end else begin
      wait_q <= wait_d;
      busy_q <= busy_d;
    end
  end

  a_no_push_when_full : assert property (@(posedge clock) disable iff (reset)
    fifo_full |-> !push);

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed self-checking bench for rf_write_scheduler (BUF_DEPTH=2, STARVE_LIMIT=4).
module tb_rf_write_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pipe_wr_en;
  logic [4:0]  pipe_wr_reg;
  logic [31:0] pipe_wr_data;
  logic        md_issue;
  logic [4:0]  md_issue_reg;
  logic [4:0]  rs, rt;
  logic        dec_stall, hold_pipe, rf_write_enable;
  logic [31:0] busy_mask;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_wr_data;

  int pass_cnt  = 0;
  int total_cnt = 0;

  rf_write_scheduler_if md_if ();

  rf_write_scheduler #(
    .BUF_DEPTH    (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .pipe_wr_en      (pipe_wr_en),
    .pipe_wr_reg     (pipe_wr_reg),
    .pipe_wr_data    (pipe_wr_data),
    .md              (md_if),
    .md_issue        (md_issue),
    .md_issue_reg    (md_issue_reg),
    .rs              (rs),
    .rt              (rt),
    .dec_stall       (dec_stall),
    .busy_mask       (busy_mask),
    .hold_pipe       (hold_pipe),
    .rf_write_enable (rf_write_enable),
    .rf_write_reg    (rf_write_reg),
    .rf_wr_data      (rf_wr_data)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    pipe_wr_en = 1'b0; pipe_wr_reg = '0; pipe_wr_data = '0;
    md_if.md_valid = 1'b0; md_if.md_reg = '0; md_if.md_data = '0;
    md_issue = 1'b0; md_issue_reg = '0; rs = '0; rt = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    idle();
    pipe_wr_en = 1'b1; pipe_wr_reg = 5'd3; pipe_wr_data = 32'h33;
    step(); step();
    #1;
    total_cnt++; if (rf_write_enable !== 1'b0) $display("FAIL rst_we got %0b want 0", rf_write_enable); else pass_cnt++;
    total_cnt++; if (rf_write_reg !== 5'd0) $display("FAIL rst_reg got %0d want 0", rf_write_reg); else pass_cnt++;
    total_cnt++; if (rf_wr_data !== 32'd0) $display("FAIL rst_data got %h want 0", rf_wr_data); else pass_cnt++;
    reset = 1'b0;
    idle();
    #1;
    total_cnt++; if (md_if.md_ready !== 1'b1) $display("FAIL rst_ready got %0b want 1", md_if.md_ready); else pass_cnt++;
    total_cnt++; if (hold_pipe !== 1'b0) $display("FAIL rst_hold got %0b want 0", hold_pipe); else pass_cnt++;
    total_cnt++; if (dec_stall !== 1'b0) $display("FAIL rst_stall got %0b want 0", dec_stall); else pass_cnt++;
    total_cnt++; if (busy_mask !== 32'd0) $display("FAIL rst_busy got %h want 0", busy_mask); else pass_cnt++;
  endtask

  task automatic test_basic_md();
    step();
    md_issue = 1'b1; md_issue_reg = 5'd5;
    step();
    idle();
    md_if.md_valid = 1'b1; md_if.md_reg = 5'd5; md_if.md_data = 32'h1234;
    #1;
    total_cnt++; if (busy_mask !== 32'h20) $display("FAIL basic_busy_set got %h want 20", busy_mask); else pass_cnt++;
    total_cnt++; if (rf_write_enable !== 1'b0) $display("FAIL basic_we_push got %0b want 0", rf_write_enable); else pass_cnt++;
    step();
    idle();
    #1;
    total_cnt++; if (rf_write_enable !== 1'b1 || rf_write_reg !== 5'd5 || rf_wr_data !== 32'h1234)
      $display("FAIL basic_write got we=%0b reg=%0d data=%h want we=1 reg=5 data=1234", rf_write_enable, rf_write_reg, rf_wr_data);
    else pass_cnt++;
    step();
    #1;
    total_cnt++; if (busy_mask !== 32'd0) $display("FAIL basic_busy_clr got %h want 0", busy_mask); else pass_cnt++;
    total_cnt++; if (rf_write_enable !== 1'b0) $display("FAIL basic_we_idle got %0b want 0", rf_write_enable); else pass_cnt++;
  endtask

  task automatic test_starvation();
    pipe_wr_en = 1'b1; pipe_wr_reg = 5'd7; pipe_wr_data = 32'h77;
    md_if.md_valid = 1'b1; md_if.md_reg = 5'd9; md_if.md_data = 32'h99;
    #1;
    total_cnt++; if (rf_write_enable !== 1'b1 || rf_write_reg !== 5'd7)
      $display("FAIL starve_c0 got we=%0b reg=%0d want we=1 reg=7", rf_write_enable, rf_write_reg);
    else pass_cnt++;
    step();
    md_if.md_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      total_cnt++; if (hold_pipe !== 1'b0 || rf_write_reg !== 5'd7)
        $display("FAIL starve_pipe cycle %0d got hold=%0b reg=%0d want hold=0 reg=7", c, hold_pipe, rf_write_reg);
      else pass_cnt++;
      step();
    end
    #1;
    total_cnt++; if (hold_pipe !== 1'b1 || rf_write_enable !== 1'b1 || rf_write_reg !== 5'd9 || rf_wr_data !== 32'h99)
      $display("FAIL starve_hold got hold=%0b we=%0b reg=%0d data=%h want 1 1 9 99", hold_pipe, rf_write_enable, rf_write_reg, rf_wr_data);
    else pass_cnt++;
    step();
    #1;
    total_cnt++; if (hold_pipe !== 1'b0 || rf_write_reg !== 5'd7 || rf_wr_data !== 32'h77)
      $display("FAIL starve_resume got hold=%0b reg=%0d data=%h want 0 7 77", hold_pipe, rf_write_reg, rf_wr_data);
    else pass_cnt++;
    idle();
    step();
  endtask

  task automatic test_full();
    int waited;
    pipe_wr_en = 1'b1; pipe_wr_reg = 5'd7; pipe_wr_data = 32'h77;
    md_if.md_valid = 1'b1; md_if.md_reg = 5'd3; md_if.md_data = 32'h3;
    #1;
    total_cnt++; if (md_if.md_ready !== 1'b1) $display("FAIL full_ready0 got %0b want 1", md_if.md_ready); else pass_cnt++;
    step();
    md_if.md_reg = 5'd4; md_if.md_data = 32'h4;
    #1;
    total_cnt++; if (md_if.md_ready !== 1'b1) $display("FAIL full_ready1 got %0b want 1", md_if.md_ready); else pass_cnt++;
    step();
    md_if.md_reg = 5'd6; md_if.md_data = 32'h6;
    #1;
    total_cnt++; if (md_if.md_ready !== 1'b0) $display("FAIL full_ready2 got %0b want 0", md_if.md_ready); else pass_cnt++;
    waited = 0;
    while (md_if.md_ready !== 1'b1 && waited < 10) begin
      step();
      waited++;
      #1;
    end
    total_cnt++; if (waited != 4) $display("FAIL full_wait got %0d cycles want 4", waited); else pass_cnt++;
    step();
    idle();
    #1;
    total_cnt++; if (rf_write_enable !== 1'b1 || rf_write_reg !== 5'd4)
      $display("FAIL full_drain0 got we=%0b reg=%0d want we=1 reg=4", rf_write_enable, rf_write_reg);
    else pass_cnt++;
    step();
    #1;
    total_cnt++; if (rf_write_enable !== 1'b1 || rf_write_reg !== 5'd6 || rf_wr_data !== 32'h6)
      $display("FAIL full_drain1 got we=%0b reg=%0d data=%h want 1 6 6", rf_write_enable, rf_write_reg, rf_wr_data);
    else pass_cnt++;
    step();
    #1;
    total_cnt++; if (rf_write_enable !== 1'b0) $display("FAIL full_empty_we got %0b want 0", rf_write_enable); else pass_cnt++;
  endtask

  task automatic test_scoreboard();
    md_issue = 1'b1; md_issue_reg = 5'd8;
    step();
    idle();
    rs = 5'd8;
    md_if.md_valid = 1'b1; md_if.md_reg = 5'd8; md_if.md_data = 32'h88;
    #1;
    total_cnt++; if (dec_stall !== 1'b1 || busy_mask !== 32'h100)
      $display("FAIL sb_set got stall=%0b busy=%h want 1 100", dec_stall, busy_mask);
    else pass_cnt++;
    step();
    md_if.md_valid = 1'b0;
    #1;
    total_cnt++; if (dec_stall !== 1'b1 || rf_write_reg !== 5'd8 || rf_write_enable !== 1'b1)
      $display("FAIL sb_pop got stall=%0b we=%0b reg=%0d want 1 1 8", dec_stall, rf_write_enable, rf_write_reg);
    else pass_cnt++;
    step();
    #1;
    total_cnt++; if (dec_stall !== 1'b0) $display("FAIL sb_clear got %0b want 0", dec_stall); else pass_cnt++;
    rs = 5'd0; rt = 5'd8;
    md_if.md_valid = 1'b1; md_if.md_reg = 5'd8; md_if.md_data = 32'h88;
    step();
    md_if.md_valid = 1'b0;
    md_issue = 1'b1; md_issue_reg = 5'd8;
    #1;
    total_cnt++; if (rf_write_enable !== 1'b1 || rf_write_reg !== 5'd8)
      $display("FAIL sb_same_pop got we=%0b reg=%0d want 1 8", rf_write_enable, rf_write_reg);
    else pass_cnt++;
    step();
    md_issue = 1'b0;
    #1;
    total_cnt++; if (busy_mask !== 32'h100 || dec_stall !== 1'b1)
      $display("FAIL sb_same_keep got busy=%h stall=%0b want 100 1", busy_mask, dec_stall);
    else pass_cnt++;
    md_if.md_valid = 1'b1; md_if.md_reg = 5'd8; md_if.md_data = 32'h1;
    step();
    idle();
    step();
    #1;
    total_cnt++; if (busy_mask !== 32'd0) $display("FAIL sb_final got %h want 0", busy_mask); else pass_cnt++;
  endtask

  task automatic test_r0();
    pipe_wr_en = 1'b1; pipe_wr_reg = 5'd0; pipe_wr_data = 32'h5;
    md_if.md_valid = 1'b1; md_if.md_reg = 5'd0; md_if.md_data = 32'hdead;
    md_issue = 1'b1; md_issue_reg = 5'd0;
    #1;
    total_cnt++; if (md_if.md_ready !== 1'b1 || rf_write_enable !== 1'b0)
      $display("FAIL r0_same got ready=%0b we=%0b want 1 0", md_if.md_ready, rf_write_enable);
    else pass_cnt++;
    step();
    step();
    md_if.md_valid = 1'b0; md_issue = 1'b0;
    #1;
    total_cnt++; if (rf_write_enable !== 1'b0 || md_if.md_ready !== 1'b1 || busy_mask !== 32'd0)
      $display("FAIL r0_after got we=%0b ready=%0b busy=%h want 0 1 0", rf_write_enable, md_if.md_ready, busy_mask);
    else pass_cnt++;
    idle();
    step();
    #1;
    total_cnt++; if (rf_write_enable !== 1'b0) $display("FAIL r0_nopop got %0b want 0", rf_write_enable); else pass_cnt++;
  endtask

  task automatic test_reset_flush();
    pipe_wr_en = 1'b1; pipe_wr_reg = 5'd7; pipe_wr_data = 32'h77;
    md_if.md_valid = 1'b1; md_if.md_reg = 5'd4; md_if.md_data = 32'h4;
    md_issue = 1'b1; md_issue_reg = 5'd4;
    step();
    md_if.md_reg = 5'd5; md_if.md_data = 32'h5; md_issue_reg = 5'd5;
    step();
    md_if.md_valid = 1'b0; md_issue = 1'b0;
    #1;
    total_cnt++; if (busy_mask !== 32'h30 || md_if.md_ready !== 1'b0)
      $display("FAIL flush_pre got busy=%h ready=%0b want 30 0", busy_mask, md_if.md_ready);
    else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++; if (rf_write_enable !== 1'b0 || rf_write_reg !== 5'd0 || rf_wr_data !== 32'd0)
      $display("FAIL flush_in_reset got we=%0b reg=%0d data=%h want 0 0 0", rf_write_enable, rf_write_reg, rf_wr_data);
    else pass_cnt++;
    step();
    reset = 1'b0;
    idle();
    #1;
    total_cnt++; if (busy_mask !== 32'd0 || md_if.md_ready !== 1'b1 || hold_pipe !== 1'b0 || rf_write_enable !== 1'b0)
      $display("FAIL flush_post got busy=%h ready=%0b hold=%0b we=%0b want 0 1 0 0", busy_mask, md_if.md_ready, hold_pipe, rf_write_enable);
    else pass_cnt++;
    step();
    #1;
    total_cnt++; if (rf_write_enable !== 1'b0) $display("FAIL flush_nowrite got %0b want 0", rf_write_enable); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_md();
    test_starvation();
    test_full();
    test_scoreboard();
    test_r0();
    test_reset_flush();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
